// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment
// constants, scan phase encoding and the BCD validity helper.
package seg_pkg;

    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // A BCD nibble is only displayable as a numeral when it is 0..9.
    function automatic logic bcd_valid(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer for the digit scan: counts cycles within a digit slot,
// sequences BLANK then SHOW, advances the digit index at slot end and
// flags the final cycle of each frame.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output scan_state_t                   state,
    output logic [$clog2(NUM_DIGITS)-1:0] idx,
    output logic                          frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [IW-1:0] idx_next;
    scan_state_t   state_next;
    logic          frame_done_next;

    // Next counter/index/phase; frame_done is looked ahead one cycle so the
    // registered pulse lands exactly on the last cycle of the last digit.
    always_comb begin
        cnt_next        = cnt + CW'(1);
        idx_next        = idx;
        state_next      = state;
        frame_done_next = 1'b0;
        if (cnt == CNT_LAST) begin
            cnt_next = {CW{1'b0}};
            if (idx == IDX_LAST) begin
                idx_next = {IW{1'b0}};
            end else begin
                idx_next = idx + IW'(1);
            end
        end else begin
            idx_next = idx;
        end
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next = SHOW;
                end else begin
                    state_next = BLANK;
                end
            end
            SHOW: begin
                if (cnt == CNT_LAST) begin
                    state_next = BLANK;
                end else begin
                    state_next = SHOW;
                end
            end
            default: state_next = BLANK;
        endcase
        frame_done_next = (cnt_next == CNT_LAST) && (idx_next == IDX_LAST);
    end

    // Slot timing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= {CW{1'b0}};
            idx        <= {IW{1'b0}};
            state      <= BLANK;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            idx        <= idx_next;
            state      <= state_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller. Holds a shadow and an active
// frame of BCD digits, swaps them only at frame boundaries, and drives
// registered segment/anode outputs from an external shared decoder.
module seven_seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic                      lz_suppress,
    output logic [3:0]                dec_bcd,
    input  logic [6:0]                seg_in,
    output logic [6:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      frame_done,
    output logic                      pending
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    scan_state_t             state;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] active;
    logic                    apply;
    logic                    upper_zero;
    logic                    suppress;

    seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .idx        (idx),
        .frame_done (frame_done)
    );

    assign dec_bcd = active[{idx, 2'b00} +: 4];
    assign apply   = frame_done & (pending | load);

    // Leading-zero blanking: walk from the top digit down, tracking whether
    // everything seen so far is zero; digit 0 always stays lit.
    always_comb begin
        upper_zero = 1'b1;
        suppress   = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (active[4*k +: 4] == 4'd0);
            if (idx == IW'(k)) begin
                suppress = lz_suppress & upper_zero & (k != 0);
            end else begin
                suppress = suppress;
            end
        end
    end

    // Frame buffering: loads land in the shadow; the active frame changes
    // only on the frame_done cycle, with a coincident load taking priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= {(4*NUM_DIGITS){1'b0}};
            active  <= {(4*NUM_DIGITS){1'b0}};
            pending <= 1'b0;
        end else begin
            if (load) begin
                shadow <= bcd_in;
            end else begin
                shadow <= shadow;
            end
            if (apply) begin
                active  <= load ? bcd_in : shadow;
                pending <= 1'b0;
            end else if (load) begin
                active  <= active;
                pending <= 1'b1;
            end else begin
                active  <= active;
                pending <= pending;
            end
        end
    end

    // Output stage: anode and segments registered together from the same
    // index so they never disagree; invalid codes show a dash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_out  <= AN_OFF;
            seg_out <= SEG_OFF;
        end else if ((state == SHOW) && !suppress) begin
            an_out  <= ~(ONE_HOT0 << idx);
            seg_out <= bcd_valid(dec_bcd) ? seg_in : SEG_DASH;
        end else begin
            an_out  <= AN_OFF;
            seg_out <= SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with a small cycle-count
// reference model and an in-bench stand-in for the shared decoder.
module tb_seven_seg_scan_ctrl;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;
    localparam int FRAME = N * R;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic        lz_suppress = 1'b0;
    logic [3:0]  dec_bcd;
    logic [6:0]  seg_in;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_done;
    logic        pending;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .bcd_in      (bcd_in),
        .lz_suppress (lz_suppress),
        .dec_bcd     (dec_bcd),
        .seg_in      (seg_in),
        .seg_out     (seg_out),
        .an_out      (an_out),
        .frame_done  (frame_done),
        .pending     (pending)
    );

    // Decoder table {a..g}; non-BCD codes give a pattern that is not the dash.
    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b1010101;
        endcase
    endfunction

    assign seg_in = dec7(dec_bcd);

    // ---------------- reference model ----------------
    function automatic int slot_cnt(input int n);
        return n % R;
    endfunction

    function automatic int slot_idx(input int n);
        return (n / R) % N;
    endfunction

    function automatic logic [3:0] digit(input logic [15:0] v, input int k);
        logic [15:0] s;
        s = v >> (4 * k);
        return s[3:0];
    endfunction

    function automatic logic is_dark(input int n, input logic [15:0] v, input logic lz);
        int k;
        k = slot_idx(n);
        if (slot_cnt(n) < B) return 1'b1;
        if (lz && k != 0 && ((v >> (4 * k)) == 16'h0000)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_an_f(input int n, input logic [15:0] v, input logic lz);
        logic [3:0] one;
        one = 4'b0001;
        if (is_dark(n, v, lz)) return 4'b1111;
        return ~(one << slot_idx(n));
    endfunction

    function automatic logic [6:0] exp_seg_f(input int n, input logic [15:0] v, input logic lz);
        logic [3:0] d;
        if (is_dark(n, v, lz)) return 7'b0000000;
        d = digit(v, slot_idx(n));
        if (d > 4'd9) return 7'b0000001;
        return dec7(d);
    endfunction

    function automatic logic is_last(input int n);
        return (slot_cnt(n) == R - 1) && (slot_idx(n) == N - 1);
    endfunction

    int          m_n = 0;
    logic [15:0] m_active = 16'h0000;
    logic [15:0] m_shadow = 16'h0000;
    logic        m_pending = 1'b0;
    logic [3:0]  m_an = 4'b1111;
    logic [6:0]  m_seg = 7'b0000000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n       <= 0;
            m_active  <= 16'h0000;
            m_shadow  <= 16'h0000;
            m_pending <= 1'b0;
            m_an      <= 4'b1111;
            m_seg     <= 7'b0000000;
        end else begin
            m_an  <= exp_an_f(m_n, m_active, lz_suppress);
            m_seg <= exp_seg_f(m_n, m_active, lz_suppress);
            if (load) m_shadow <= bcd_in;
            if (is_last(m_n) && (m_pending || load)) begin
                m_active  <= load ? bcd_in : m_shadow;
                m_pending <= 1'b0;
            end else if (load) begin
                m_pending <= 1'b1;
            end
            m_n <= m_n + 1;
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (an_out !== 4'b1111) begin bad++; $display("FAIL reset_an: got %b want 1111", an_out); end
        total++; if (seg_out !== 7'b0000000) begin bad++; $display("FAIL reset_seg: got %b want 0000000", seg_out); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL reset_pending: got %b want 0", pending); end
        total++; if (dec_bcd !== 4'd0) begin bad++; $display("FAIL reset_dec: got %h want 0", dec_bcd); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        int last_fd;
        last_fd = -1;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (i == 2) begin
                total++; if (an_out !== 4'b1111) begin bad++; $display("FAIL idle_blank2: got %b want 1111", an_out); end
            end
            if (i == 3) begin
                total++; if (an_out !== 4'b1110) begin bad++; $display("FAIL idle_show: got %b want 1110", an_out); end
            end
            total++; if (an_out !== m_an) begin bad++; $display("FAIL idle_an c%0d: got %b want %b", i, an_out, m_an); end
            total++; if (seg_out !== m_seg) begin bad++; $display("FAIL idle_seg c%0d: got %b want %b", i, seg_out, m_seg); end
            total++; if (frame_done !== is_last(m_n)) begin bad++; $display("FAIL idle_fd c%0d: got %b want %b", i, frame_done, is_last(m_n)); end
            if (frame_done === 1'b1) begin
                if (last_fd >= 0) begin
                    total++; if (i - last_fd != FRAME) begin bad++; $display("FAIL idle_fd_period: got %0d want %0d", i - last_fd, FRAME); end
                end
                last_fd = i;
            end
        end
    endtask

    task automatic test_load(input logic [15:0] val, input logic lz, input string name);
        @(negedge clk);
        lz_suppress = lz;
        load = 1'b1;
        bcd_in = val;
        @(negedge clk);
        load = 1'b0;
        bcd_in = $urandom;
        total++; if (pending !== m_pending) begin bad++; $display("FAIL %s_pending: got %b want %b", name, pending, m_pending); end
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            @(negedge clk);
            total++; if (dec_bcd !== digit(m_active, slot_idx(m_n))) begin bad++; $display("FAIL %s_dec: got %h want %h", name, dec_bcd, digit(m_active, slot_idx(m_n))); end
            total++; if (an_out !== m_an) begin bad++; $display("FAIL %s_an: got %b want %b", name, an_out, m_an); end
            total++; if (seg_out !== m_seg) begin bad++; $display("FAIL %s_seg: got %b want %b", name, seg_out, m_seg); end
            total++; if (pending !== m_pending) begin bad++; $display("FAIL %s_pend: got %b want %b", name, pending, m_pending); end
        end
    endtask

    task automatic test_spot_values();
        // After test_load(16'h00A5, lz=1) the active frame is 00A5.
        int seen;
        seen = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (an_out === 4'b1101) begin
                seen++;
                total++; if (seg_out !== 7'b0000001) begin bad++; $display("FAIL spot_dash: got %b want 0000001", seg_out); end
            end
            if (an_out === 4'b1110) begin
                seen++;
                total++; if (seg_out !== 7'b1011011) begin bad++; $display("FAIL spot_five: got %b want 1011011", seg_out); end
            end
            total++; if (an_out[3:2] !== 2'b11) begin bad++; $display("FAIL spot_dark: got %b want 11xx", an_out); end
        end
        total++; if (seen != 2 * (R - B)) begin bad++; $display("FAIL spot_lit_cycles: got %0d want %0d", seen, 2 * (R - B)); end
    endtask

    task automatic test_back_to_back();
        int waited;
        lz_suppress = 1'b0;
        waited = 0;
        while (slot_cnt(m_n) != 3 || slot_idx(m_n) != 1) begin
            @(negedge clk);
            waited++;
            if (waited > 2 * FRAME) break;
        end
        load = 1'b1; bcd_in = 16'h1111;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        load = 1'b1; bcd_in = 16'h2222;
        @(negedge clk);
        load = 1'b0;
        total++; if (pending !== 1'b1) begin bad++; $display("FAIL b2b_pending_set: got %b want 1", pending); end
        waited = 0;
        while (frame_done !== 1'b1 && waited < 2 * FRAME) begin
            @(negedge clk);
            waited++;
        end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL b2b_fd_timeout: got %b want 1", frame_done); end
        load = 1'b1; bcd_in = 16'h3333;
        @(negedge clk);
        load = 1'b0;
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL b2b_pending_clr: got %b want 0", pending); end
        for (int i = 0; i < FRAME; i++) begin
            total++; if (dec_bcd !== 4'd3) begin bad++; $display("FAIL b2b_dec: got %h want 3", dec_bcd); end
            total++; if (an_out !== m_an) begin bad++; $display("FAIL b2b_an: got %b want %b", an_out, m_an); end
            total++; if (seg_out !== m_seg) begin bad++; $display("FAIL b2b_seg: got %b want %b", seg_out, m_seg); end
            @(negedge clk);
        end
    endtask

    task automatic test_midreset();
        int waited;
        waited = 0;
        while (an_out !== 4'b1011 && waited < 2 * FRAME) begin
            @(negedge clk);
            waited++;
        end
        total++; if (an_out !== 4'b1011) begin bad++; $display("FAIL mrst_wait: got %b want 1011", an_out); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (an_out !== 4'b1111) begin bad++; $display("FAIL mrst_an: got %b want 1111", an_out); end
        total++; if (seg_out !== 7'b0000000) begin bad++; $display("FAIL mrst_seg: got %b want 0000000", seg_out); end
        total++; if (dec_bcd !== 4'd0) begin bad++; $display("FAIL mrst_dec: got %h want 0", dec_bcd); end
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL mrst_pending: got %b want 0", pending); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= FRAME + 4; i++) begin
            @(negedge clk);
            total++; if (dec_bcd !== 4'd0) begin bad++; $display("FAIL mrst_dec_after: got %h want 0", dec_bcd); end
            total++; if (an_out !== m_an) begin bad++; $display("FAIL mrst_an_after c%0d: got %b want %b", i, an_out, m_an); end
            total++; if (frame_done !== is_last(m_n)) begin bad++; $display("FAIL mrst_fd c%0d: got %b want %b", i, frame_done, is_last(m_n)); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            total++; if (an_out !== m_an) begin bad++; $display("FAIL rnd_an c%0d: got %b want %b", i, an_out, m_an); end
            total++; if (seg_out !== m_seg) begin bad++; $display("FAIL rnd_seg c%0d: got %b want %b", i, seg_out, m_seg); end
            total++; if (frame_done !== is_last(m_n)) begin bad++; $display("FAIL rnd_fd c%0d: got %b want %b", i, frame_done, is_last(m_n)); end
            total++; if (pending !== m_pending) begin bad++; $display("FAIL rnd_pend c%0d: got %b want %b", i, pending, m_pending); end
            total++; if (dec_bcd !== digit(m_active, slot_idx(m_n))) begin bad++; $display("FAIL rnd_dec c%0d: got %h want %h", i, dec_bcd, digit(m_active, slot_idx(m_n))); end
            load = ($urandom_range(0, 5) == 0);
            bcd_in = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            if (i % 100 == 0) lz_suppress = 1'($urandom_range(0, 1));
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load(16'h1234, 1'b0, "ld1234");
        test_load(16'h0070, 1'b1, "ld0070");
        test_load(16'h00A5, 1'b1, "ld00a5");
        test_spot_values();
        test_back_to_back();
        test_midreset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
